timer_display_driver: RTL and testbench

TIMER_DISPLAY_DRIVER -- requirements
Module: timer_display_driver

---
 rtl/timer_display_pkg.sv | 27 ++
 rtl/bcd_to_seg7.sv | 21 ++
 rtl/timer_display_driver.sv | 159 +++++++++++++++
 tb/tb_timer_display_driver.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_display_pkg.sv
// -----------------------------------------------------------------------------
// timer_display_pkg
// Shared definitions for the two-digit seven-segment timer display driver:
//   - state_t       : scan FSM states (guard / show slot for each digit)
//   - GUARD_CYCLES  : dark cycles before each digit slot (anti-ghosting)
//   - SEG_TABLE     : active-high segment patterns for BCD 0..9 (bit0=a..bit6=g)
//   - DASH          : pattern shown for non-BCD inputs 10..15
// -----------------------------------------------------------------------------
package timer_display_pkg;

  typedef enum logic [1:0] {
    S_GUARD0 = 2'd0,
    S_SHOW0  = 2'd1,
    S_GUARD1 = 2'd2,
    S_SHOW1  = 2'd3
  } state_t;

  localparam int GUARD_CYCLES = 2;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] DASH = 7'h40;

endpackage

// File: rtl/bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
// Combinational 4-bit BCD to seven-segment decoder. Digits 0..9 use the
// package table; 10..15 show a dash so a corrupted timer value is visible.
// Ports:
//   digit : input  [3:0] value to decode
//   seg   : output [6:0] active-high segments, bit0=a .. bit6=g
// -----------------------------------------------------------------------------
module bcd_to_seg7
  import timer_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    if (digit < 4'd10) seg = SEG_TABLE[digit];
    else               seg = DASH;
  end

endmodule

// File: rtl/timer_display_driver.sv
// -----------------------------------------------------------------------------
// timer_display_driver
// Time-multiplexes a two-digit seconds value onto a common seven-segment bus.
// Each frame is GUARD0 (dark) -> SHOW0 (units) -> GUARD1 (dark) -> SHOW1
// (tens), SCAN_DIV cycles per digit. The BCD inputs are snapshotted at the
// start of every frame so a digit never changes mid-frame. All outputs are
// registered and lag the FSM by one cycle.
//
// Optional feature (macro TIMER_DISPLAY_BLINK_EN): while Time_Out is high the
// whole display blinks, toggling every BLINK_DIV frames. Without the macro the
// display is steady.
//
// Parameters:
//   SCAN_DIV  : clock cycles per digit slot (>= 4)
//   BLINK_DIV : frames per blink half-period (>= 1)
// Ports:
//   Clock      : input        rising-edge clock
//   Reset      : input        synchronous, active-high
//   Sec1       : input  [3:0] BCD tens digit
//   Sec0       : input  [3:0] BCD units digit
//   Time_Out   : input        timer at terminal value (drives Dp / blink)
//   Blank_Lead : input        suppress a leading zero in the tens digit
//   Seg        : output [6:0] segments, active-high, bit0=a .. bit6=g
//   Digit_En   : output [1:0] digit enables, bit0=units, bit1=tens
//   Dp         : output       decimal point, lit only in the tens slot
// -----------------------------------------------------------------------------
module timer_display_driver
  import timer_display_pkg::*;
#(
  parameter int SCAN_DIV  = 1024,
  parameter int BLINK_DIV = 64
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Sec1,
  input  logic [3:0] Sec0,
  input  logic       Time_Out,
  input  logic       Blank_Lead,
  output logic [6:0] Seg,
  output logic [1:0] Digit_En,
  output logic       Dp
);

  localparam int CNT_W = $clog2(SCAN_DIV);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       snap1;
  logic [3:0]       snap0;
  logic             last_cycle;
  logic             frame_end;
  logic [3:0]       mux_digit;
  logic [6:0]       dec_seg;
  logic             phase_on;
  logic [1:0]       en_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // Guards run GUARD_CYCLES cycles, show slots fill the rest of SCAN_DIV.
  always_comb begin
    if (state == S_GUARD0 || state == S_GUARD1)
      last_cycle = (cnt == CNT_W'(GUARD_CYCLES - 1));
    else
      last_cycle = (cnt == CNT_W'(SCAN_DIV - GUARD_CYCLES - 1));
  end

  assign frame_end = last_cycle && (state == S_SHOW1);

  // Single decoder shared by both digits; the mux picks the digit whose
  // slot is current so the registered output lines up with Digit_En.
  assign mux_digit = (state == S_SHOW1) ? snap1 : snap0;

  bcd_to_seg7 u_dec (
    .digit (mux_digit),
    .seg   (dec_seg)
  );

`ifdef TIMER_DISPLAY_BLINK_EN
  localparam int FC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FC_W-1:0] frame_cnt;
  logic            blink_on;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!Time_Out) begin
      // Blinking only makes sense at the terminal value; leave the phase lit
      // so the next timeout starts with a full visible half-period.
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FC_W'(BLINK_DIV - 1)) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign phase_on = blink_on;
`else
  assign phase_on = 1'b1;
`endif

  // NOTE: every variable gets a default first so this block cannot infer a latch.
  always_comb begin
    en_next  = 2'b00;
    seg_next = 7'h00;
    dp_next  = 1'b0;
    case (state)
      S_SHOW0: en_next = 2'b01;
      S_SHOW1: if (!(Blank_Lead && snap1 == 4'd0)) en_next = 2'b10;
      default: en_next = 2'b00;
    endcase
    if (!phase_on) en_next = 2'b00;
    if (en_next != 2'b00) seg_next = dec_seg;
    dp_next = en_next[1] & Time_Out;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= S_GUARD0;
      cnt      <= '0;
      snap1    <= 4'd0;
      snap0    <= 4'd0;
      Seg      <= 7'h00;
      Digit_En <= 2'b00;
      Dp       <= 1'b0;
    end else begin
      Seg      <= seg_next;
      Digit_En <= en_next;
      Dp       <= dp_next;

      // Fresh snapshot once per frame, on entry to GUARD0.
      if (state == S_GUARD0 && cnt == '0) begin
        snap1 <= Sec1;
        snap0 <= Sec0;
      end

      if (last_cycle) begin
        cnt <= '0;
        case (state)
          S_GUARD0: state <= S_SHOW0;
          S_SHOW0:  state <= S_GUARD1;
          S_GUARD1: state <= S_SHOW1;
          default:  state <= S_GUARD0;
        endcase
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_timer_display_driver.sv
// -----------------------------------------------------------------------------
// tb_timer_display_driver
// Self-checking bench: a frame-position model predicts every output cycle,
// plus directed scenarios for snapshot timing, leading-zero blanking, the
// dash pattern and reset mid-frame. Follows TIMER_DISPLAY_BLINK_EN if defined.
// -----------------------------------------------------------------------------
module tb_timer_display_driver;

  localparam int SCAN_DIV  = 8;
  localparam int BLINK_DIV = 2;
  localparam int FRAME     = 2 * SCAN_DIV;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Sec1 = 4'd4;
  logic [3:0] Sec0 = 4'd2;
  logic       Time_Out = 1'b0;
  logic       Blank_Lead = 1'b0;
  logic [6:0] Seg;
  logic [1:0] Digit_En;
  logic       Dp;

  int n_checks = 0;
  int n_errors = 0;
  bit model_on = 1'b0;

  timer_display_driver #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Sec1       (Sec1),
    .Sec0       (Sec0),
    .Time_Out   (Time_Out),
    .Blank_Lead (Blank_Lead),
    .Seg        (Seg),
    .Digit_En   (Digit_En),
    .Dp         (Dp)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // Reference model: position within the frame since the last reset, the
  // digits latched at position 0, and the blink phase / frame count.
  int         m_pos = 0;
  logic [3:0] m_s1 = 4'd0, m_s0 = 4'd0;
  bit         m_phase = 1'b1;
  int         m_fc = 0;
  logic [6:0] e_seg = 7'h00;
  logic [1:0] e_en = 2'b00;
  logic       e_dp = 1'b0;

  always @(posedge Clock) begin
    if (Reset) begin
      m_pos <= 0; m_s1 <= 4'd0; m_s0 <= 4'd0; m_phase <= 1'b1; m_fc <= 0;
      e_seg <= 7'h00; e_en <= 2'b00; e_dp <= 1'b0;
    end else begin
      logic [1:0] en;
      en = 2'b00;
      if (m_pos >= 2 && m_pos < SCAN_DIV) en = 2'b01;
      else if (m_pos >= SCAN_DIV + 2 && !(Blank_Lead && m_s1 == 4'd0)) en = 2'b10;
`ifdef TIMER_DISPLAY_BLINK_EN
      if (!m_phase) en = 2'b00;
`endif
      e_en  <= en;
      e_seg <= (en == 2'b01) ? seg_of(m_s0) : (en == 2'b10) ? seg_of(m_s1) : 7'h00;
      e_dp  <= (en == 2'b10) && Time_Out;
      if (m_pos == 0) begin m_s1 <= Sec1; m_s0 <= Sec0; end
      m_pos <= (m_pos + 1) % FRAME;
`ifdef TIMER_DISPLAY_BLINK_EN
      if (!Time_Out) begin
        m_fc <= 0; m_phase <= 1'b1;
      end else if (m_pos == FRAME - 1) begin
        if (m_fc == BLINK_DIV - 1) begin m_fc <= 0; m_phase <= !m_phase; end
        else m_fc <= m_fc + 1;
      end
`endif
    end
  end

  always @(negedge Clock) begin
    if (model_on) begin
      check("model_seg", 32'(Seg), 32'(e_seg));
      check("model_en",  32'(Digit_En), 32'(e_en));
      check("model_dp",  32'(Dp), 32'(e_dp));
    end
  end

  // Waits (at negedges) until Digit_En equals want; a missed deadline is a failure.
  task automatic wait_en(input string tag, input logic [1:0] want, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge Clock);
      if (Digit_En == want) begin ok = 1'b1; break; end
    end
    check({tag, "_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge Clock);
    Reset = 1'b1;
    repeat (cycles) @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    int cnt10;
    @(posedge Clock);
    @(negedge Clock);
    check("reset_seg", 32'(Seg), 32'h0);
    check("reset_en",  32'(Digit_En), 32'h0);
    check("reset_dp",  32'(Dp), 32'h0);
    model_on = 1'b1;
    Reset = 1'b0;

    // Release with 4/2: three dark cycles (reset-registered + 2 guard), then units.
    repeat (2) begin @(negedge Clock); check("rel_guard_en", 32'(Digit_En), 32'h0); end
    @(negedge Clock);
    check("rel_units_en",  32'(Digit_En), 32'h1);
    check("rel_units_seg", 32'(Seg), 32'h5B);
    wait_en("tens42", 2'b10, 20);
    check("tens42_seg", 32'(Seg), 32'h66);

    // Mid-frame change of Sec0 must wait for the next frame.
    Sec0 = 4'd3;
    @(negedge Clock);
    check("hold_tens_seg", 32'(Seg), 32'h66);
    wait_en("next_units", 2'b01, 20);
    check("next_units_seg", 32'(Seg), 32'h4F);

    // Leading-zero blanking.
    Sec1 = 4'd0; Sec0 = 4'd7; Blank_Lead = 1'b1;
    repeat (FRAME) @(negedge Clock);
    cnt10 = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge Clock);
      if (Digit_En == 2'b10) cnt10++;
    end
    check("blank_no_tens", 32'(cnt10), 32'd0);
    wait_en("blank_units", 2'b01, 20);
    check("blank_units_seg", 32'(Seg), 32'h07);
    Blank_Lead = 1'b0;
    wait_en("zero_tens", 2'b10, 20);
    check("zero_tens_seg", 32'(Seg), 32'h3F);

    // Non-BCD value shows a dash.
    Sec0 = 4'hC;
    repeat (FRAME) @(negedge Clock);
    wait_en("dash_units", 2'b01, 20);
    check("dash_seg", 32'(Seg), 32'h40);

    // Reset pulsed for one cycle during the tens slot.
    Sec1 = 4'd5; Sec0 = 4'd2;
    wait_en("pre_rst_tens", 2'b10, 2 * FRAME);
    Sec0 = 4'd9;
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check("rst_pulse_en",  32'(Digit_En), 32'h0);
    check("rst_pulse_seg", 32'(Seg), 32'h0);
    check("rst_pulse_dp",  32'(Dp), 32'h0);
    repeat (2) begin @(negedge Clock); check("rst_guard_en", 32'(Digit_En), 32'h0); end
    @(negedge Clock);
    check("rst_units_en",  32'(Digit_En), 32'h1);
    check("rst_units_seg", 32'(Seg), 32'h6F);

    // Timeout: Dp in tens slots (and blinking when enabled), then steady again.
    Time_Out = 1'b1;
    wait_en("dp_tens", 2'b10, 2 * FRAME);
    check("dp_on_tens", 32'(Dp), 32'h1);
    repeat (8 * FRAME) @(negedge Clock);
    Time_Out = 1'b0;
    repeat (2 * FRAME) @(negedge Clock);

    // Randomized traffic; the model checks every cycle.
    for (int k = 0; k < 60; k++) begin
      Sec1       = 4'($urandom_range(0, 15));
      Sec0       = 4'($urandom_range(0, 15));
      Blank_Lead = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) Time_Out = ~Time_Out;
      if ($urandom_range(0, 9) == 0) do_reset($urandom_range(1, 2));
      repeat ($urandom_range(1, 40)) @(negedge Clock);
    end
    Time_Out = 1'b1;
    repeat (10 * FRAME) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
